// File: rtl/memory.sv
// Dual-port word memory: a read-only instruction port and a read/write data port,
// each with a fixed LATENCY handshake. Reset clears the array.
module memory #(
  parameter int READ_SIZE = 64,
  parameter int CACHE     = 1,
  parameter int LATENCY   = 2,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [15:0]          i_address,
  inout  wire  [READ_SIZE-1:0] i_data,
  output logic                 i_readyM,
  output logic                 i_input_readyM,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [15:0]          d_address,
  inout  wire  [READ_SIZE-1:0] d_data,
  output logic                 d_readyM,
  output logic                 d_input_readyM,
  output logic                 d_doneM,
  output logic [15:0]          d_written_address
);

  localparam int WPL = READ_SIZE / 16;
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam logic [15:0] LINE_MASK = (CACHE != 0) ? ~16'(WPL - 1) : 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_RBUSY, ST_RDONE, ST_WBUSY} port_state_t;

  logic [15:0] mem [MEM_DEPTH];

  port_state_t          i_state, i_state_n, d_state, d_state_n;
  logic [CW-1:0]        i_cnt, i_cnt_n, d_cnt, d_cnt_n;
  logic [15:0]          i_addr_q, i_addr_n, d_addr_q, d_addr_n;
  logic [READ_SIZE-1:0] i_rdata_q, i_rdata_n, d_rdata_q, d_rdata_n;
  logic [READ_SIZE-1:0] i_line, d_line;
  logic [15:0]          wr_addr_q, wr_addr_n, wr_data_q, wr_data_n;
  logic [15:0]          written_q, written_n;
  logic                 done_q, done_n;
  logic                 run_q;
  logic                 wr_fire;
  logic [15:0]          ia, da;
  logic                 unused_bits;

  assign unused_bits = ^{i_writeM, d_data};

  assign wr_fire = (d_state == ST_WBUSY) && (d_cnt <= CW'(1));

  // Line assembly forwards a write completing on the same edge so a read
  // entering RDONE then captures the new word.
  always_comb begin
    i_line = '0;
    d_line = '0;
    ia     = '0;
    da     = '0;
    for (int unsigned k = 0; k < WPL; k++) begin
      ia = (i_addr_q & LINE_MASK) + 16'(k);
      da = (d_addr_q & LINE_MASK) + 16'(k);
      i_line[16*k +: 16] = (wr_fire && (wr_addr_q[AW-1:0] == ia[AW-1:0])) ?
                           wr_data_q : mem[ia[AW-1:0]];
      d_line[16*k +: 16] = (wr_fire && (wr_addr_q[AW-1:0] == da[AW-1:0])) ?
                           wr_data_q : mem[da[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < MEM_DEPTH; n++) mem[n] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr_q[AW-1:0]] <= wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_state   <= ST_IDLE;
      i_cnt     <= '0;
      i_addr_q  <= '0;
      i_rdata_q <= '0;
      d_state   <= ST_IDLE;
      d_cnt     <= '0;
      d_addr_q  <= '0;
      d_rdata_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      written_q <= '0;
      done_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      i_state   <= i_state_n;
      i_cnt     <= i_cnt_n;
      i_addr_q  <= i_addr_n;
      i_rdata_q <= i_rdata_n;
      d_state   <= d_state_n;
      d_cnt     <= d_cnt_n;
      d_addr_q  <= d_addr_n;
      d_rdata_q <= d_rdata_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      written_q <= written_n;
      done_q    <= done_n;
      run_q     <= 1'b1;
    end
  end

  always_comb begin
    i_state_n = i_state;
    i_cnt_n   = i_cnt;
    i_addr_n  = i_addr_q;
    i_rdata_n = i_rdata_q;
    case (i_state)
      ST_IDLE: begin
        if (i_readM) begin
          i_state_n = ST_RBUSY;
          i_cnt_n   = CW'(LATENCY);
          i_addr_n  = i_address;
        end
      end
      ST_RBUSY: begin
        if (!i_readM) begin
          i_state_n = ST_IDLE;
        end else if (i_address != i_addr_q) begin
          i_cnt_n  = CW'(LATENCY);
          i_addr_n = i_address;
        end else if (i_cnt <= CW'(1)) begin
          i_state_n = ST_RDONE;
          i_rdata_n = i_line;
        end else begin
          i_cnt_n = i_cnt - CW'(1);
        end
      end
      ST_RDONE: begin
        if (!i_readM) begin
          i_state_n = ST_IDLE;
        end else if (i_address != i_addr_q) begin
          i_state_n = ST_RBUSY;
          i_cnt_n   = CW'(LATENCY);
          i_addr_n  = i_address;
        end
      end
      default: i_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    d_state_n = d_state;
    d_cnt_n   = d_cnt;
    d_addr_n  = d_addr_q;
    d_rdata_n = d_rdata_q;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    written_n = written_q;
    done_n    = 1'b0;
    case (d_state)
      ST_IDLE: begin
        if (d_writeM && d_input_readyM) begin
          d_state_n = ST_WBUSY;
          d_cnt_n   = CW'(LATENCY);
          wr_addr_n = d_address;
          wr_data_n = d_data[15:0];
        end else if (d_readM) begin
          d_state_n = ST_RBUSY;
          d_cnt_n   = CW'(LATENCY);
          d_addr_n  = d_address;
        end
      end
      ST_RBUSY: begin
        if (!d_readM) begin
          d_state_n = ST_IDLE;
        end else if (d_address != d_addr_q) begin
          d_cnt_n  = CW'(LATENCY);
          d_addr_n = d_address;
        end else if (d_cnt <= CW'(1)) begin
          d_state_n = ST_RDONE;
          d_rdata_n = d_line;
        end else begin
          d_cnt_n = d_cnt - CW'(1);
        end
      end
      ST_RDONE: begin
        if (!d_readM) begin
          d_state_n = ST_IDLE;
        end else if (d_address != d_addr_q) begin
          d_state_n = ST_RBUSY;
          d_cnt_n   = CW'(LATENCY);
          d_addr_n  = d_address;
        end
      end
      ST_WBUSY: begin
        if (wr_fire) begin
          d_state_n = ST_IDLE;
          done_n    = 1'b1;
          written_n = wr_addr_q;
        end else begin
          d_cnt_n = d_cnt - CW'(1);
        end
      end
      default: d_state_n = ST_IDLE;
    endcase
  end

  assign i_readyM          = (i_state == ST_RDONE);
  assign i_input_readyM    = 1'b0;
  assign d_readyM          = (d_state == ST_RDONE);
  assign d_input_readyM    = (d_state == ST_IDLE) && run_q;
  assign d_doneM           = done_q;
  assign d_written_address = written_q;

  assign i_data = i_readyM ? i_rdata_q : 'z;
  assign d_data = (d_readyM && !d_writeM) ? d_rdata_q : 'z;

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: a line-read instance (defaults) and a
// single-word instance (READ_SIZE=16, CACHE=0) share clock and reset.
module tb_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  // line instance
  logic        l_i_readM, l_i_writeM, l_d_readM, l_d_writeM;
  logic [15:0] l_i_address, l_d_address;
  wire  [63:0] l_i_data, l_d_data;
  logic        l_i_readyM, l_i_input_readyM, l_d_readyM, l_d_input_readyM, l_d_doneM;
  logic [15:0] l_d_written_address;
  logic        l_drive;
  logic [63:0] l_wdata;
  assign l_d_data = l_drive ? l_wdata : 'z;

  // word instance
  logic        w_i_readM, w_i_writeM, w_d_readM, w_d_writeM;
  logic [15:0] w_i_address, w_d_address;
  wire  [15:0] w_i_data, w_d_data;
  logic        w_i_readyM, w_i_input_readyM, w_d_readyM, w_d_input_readyM, w_d_doneM;
  logic [15:0] w_d_written_address;
  logic        w_drive;
  logic [15:0] w_wdata;
  assign w_d_data = w_drive ? w_wdata : 'z;

  memory u_line (
    .clk(clk), .reset_n(reset_n),
    .i_readM(l_i_readM), .i_writeM(l_i_writeM), .i_address(l_i_address),
    .i_data(l_i_data), .i_readyM(l_i_readyM), .i_input_readyM(l_i_input_readyM),
    .d_readM(l_d_readM), .d_writeM(l_d_writeM), .d_address(l_d_address),
    .d_data(l_d_data), .d_readyM(l_d_readyM), .d_input_readyM(l_d_input_readyM),
    .d_doneM(l_d_doneM), .d_written_address(l_d_written_address)
  );

  memory #(.READ_SIZE(16), .CACHE(0), .LATENCY(2), .MEM_DEPTH(256)) u_word (
    .clk(clk), .reset_n(reset_n),
    .i_readM(w_i_readM), .i_writeM(w_i_writeM), .i_address(w_i_address),
    .i_data(w_i_data), .i_readyM(w_i_readyM), .i_input_readyM(w_i_input_readyM),
    .d_readM(w_d_readM), .d_writeM(w_d_writeM), .d_address(w_d_address),
    .d_data(w_d_data), .d_readyM(w_d_readyM), .d_input_readyM(w_d_input_readyM),
    .d_doneM(w_d_doneM), .d_written_address(w_d_written_address)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic l_write(input logic [15:0] a, input logic [15:0] v, output int lat);
    l_d_writeM = 1'b1; l_d_address = a; l_wdata = {48'h0, v}; l_drive = 1'b1;
    tick();
    l_d_writeM = 1'b0; l_drive = 1'b0;
    lat = 0;
    while (!l_d_doneM && lat < 10) begin tick(); lat++; end
  endtask

  task automatic l_iread(input logic [15:0] a, output int lat, output logic [63:0] d);
    l_i_readM = 1'b1; l_i_address = a;
    tick();
    lat = 0;
    while (!l_i_readyM && lat < 10) begin tick(); lat++; end
    d = l_i_data;
    l_i_readM = 1'b0;
    tick();
  endtask

  task automatic l_dread(input logic [15:0] a, output int lat, output logic [63:0] d);
    l_d_readM = 1'b1; l_d_address = a;
    tick();
    lat = 0;
    while (!l_d_readyM && lat < 10) begin tick(); lat++; end
    d = l_d_data;
    l_d_readM = 1'b0;
    tick();
  endtask

  task automatic w_write(input logic [15:0] a, input logic [15:0] v, output int lat);
    w_d_writeM = 1'b1; w_d_address = a; w_wdata = v; w_drive = 1'b1;
    tick();
    w_d_writeM = 1'b0; w_drive = 1'b0;
    lat = 0;
    while (!w_d_doneM && lat < 10) begin tick(); lat++; end
  endtask

  task automatic w_dread(input logic [15:0] a, output int lat, output logic [15:0] d);
    w_d_readM = 1'b1; w_d_address = a;
    tick();
    lat = 0;
    while (!w_d_readyM && lat < 10) begin tick(); lat++; end
    d = w_d_data;
    w_d_readM = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [63:0] ld;
    logic [15:0] wd;

    reset_n = 1'b0;
    l_i_readM = 0; l_i_writeM = 0; l_d_readM = 0; l_d_writeM = 0;
    l_i_address = '0; l_d_address = '0; l_drive = 0; l_wdata = '0;
    w_i_readM = 0; w_i_writeM = 0; w_d_readM = 0; w_d_writeM = 0;
    w_i_address = '0; w_d_address = '0; w_drive = 0; w_wdata = '0;
    tick(); tick();

    check("rst_i_ready",   {63'h0, l_i_readyM}, 64'h0);
    check("rst_d_ready",   {63'h0, l_d_readyM}, 64'h0);
    check("rst_done",      {63'h0, l_d_doneM}, 64'h0);
    check("rst_in_ready",  {63'h0, l_d_input_readyM}, 64'h0);
    check("rst_wr_addr",   {48'h0, l_d_written_address}, 64'h0);
    check("i_in_ready_0",  {63'h0, l_i_input_readyM}, 64'h0);

    reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", {63'h0, l_d_input_readyM}, 64'h1);

    l_write(16'h0000, 16'h1111, lat);
    check("wr0_lat", lat, 2);
    l_write(16'h0001, 16'h2222, lat);
    l_write(16'h0002, 16'h3333, lat);
    l_write(16'h0003, 16'h4444, lat);
    l_write(16'h0004, 16'hBEEF, lat);
    check("wr4_addr", {48'h0, l_d_written_address}, 64'h0004);
    tick();

    l_iread(16'h0002, lat, ld);
    check("iread2_lat", lat, 2);
    check("iread2_data", ld, 64'h4444_3333_2222_1111);
    l_iread(16'h0102, lat, ld);
    check("iread_wrap", ld, 64'h4444_3333_2222_1111);

    // write 00A5 to 0010 with per-cycle handshake checks
    l_d_writeM = 1'b1; l_d_address = 16'h0010; l_wdata = 64'h00A5; l_drive = 1'b1;
    tick();
    l_d_writeM = 1'b0; l_drive = 1'b0;
    check("wbusy_in_ready_c1", {63'h0, l_d_input_readyM}, 64'h0);
    tick();
    check("wbusy_in_ready_c2", {63'h0, l_d_input_readyM}, 64'h0);
    check("wbusy_no_done",     {63'h0, l_d_doneM}, 64'h0);
    tick();
    check("wdone_pulse",       {63'h0, l_d_doneM}, 64'h1);
    check("wdone_addr",        {48'h0, l_d_written_address}, 64'h0010);
    check("wdone_in_ready",    {63'h0, l_d_input_readyM}, 64'h1);
    tick();
    check("wdone_pulse_end",   {63'h0, l_d_doneM}, 64'h0);
    check("wdone_addr_hold",   {48'h0, l_d_written_address}, 64'h0010);

    l_dread(16'h0010, lat, ld);
    check("dread10_lat", lat, 2);
    check("dread10_data", ld, 64'h0000_0000_0000_00A5);

    // read and write together: write wins, read follows with new data
    l_d_readM = 1'b1; l_d_writeM = 1'b1; l_d_address = 16'h0011;
    l_wdata = 64'h5A5A; l_drive = 1'b1;
    tick();
    l_d_writeM = 1'b0; l_drive = 1'b0;
    lat = 0;
    while (!l_d_doneM && lat < 10) begin tick(); lat++; end
    check("rw_done_lat", lat, 2);
    check("rw_no_ready_at_done", {63'h0, l_d_readyM}, 64'h0);
    lat = 0;
    while (!l_d_readyM && lat < 10) begin tick(); lat++; end
    check("rw_read_lat", lat, 3);
    check("rw_read_data", l_d_data, 64'h0000_0000_5A5A_00A5);
    tick();
    check("rw_ready_hold", {63'h0, l_d_readyM}, 64'h1);
    l_d_readM = 1'b0;
    tick();
    check("rw_ready_drop", {63'h0, l_d_readyM}, 64'h0);

    // address change during RBUSY restarts the access
    l_i_readM = 1'b1; l_i_address = 16'h0000;
    tick();
    check("chg_busy0", {63'h0, l_i_readyM}, 64'h0);
    l_i_address = 16'h0004;
    tick();
    check("chg_busy1", {63'h0, l_i_readyM}, 64'h0);
    tick();
    check("chg_no_stale", {63'h0, l_i_readyM}, 64'h0);
    tick();
    check("chg_ready", {63'h0, l_i_readyM}, 64'h1);
    check("chg_data", l_i_data, 64'h0000_0000_0000_BEEF);
    l_i_readM = 1'b0;
    tick();

    // readM dropped during RBUSY aborts
    l_i_readM = 1'b1; l_i_address = 16'h0008;
    tick();
    l_i_readM = 1'b0;
    tick(); tick(); tick();
    check("abort_no_ready", {63'h0, l_i_readyM}, 64'h0);

    // instruction read entering RDONE on the edge a data write lands
    l_d_writeM = 1'b1; l_d_address = 16'h0015; l_wdata = 64'h7777; l_drive = 1'b1;
    l_i_readM = 1'b1; l_i_address = 16'h0014;
    tick();
    l_d_writeM = 1'b0; l_drive = 1'b0;
    tick(); tick();
    check("fwd_i_ready", {63'h0, l_i_readyM}, 64'h1);
    check("fwd_done",    {63'h0, l_d_doneM}, 64'h1);
    check("fwd_data",    l_i_data, 64'h0000_0000_7777_0000);
    l_i_readM = 1'b0;
    tick();

    // single-word instance
    w_write(16'h0003, 16'h3C3C, lat);
    check("w_wr_lat", lat, 2);
    w_dread(16'h0003, lat, wd);
    check("w_read3_lat", lat, 2);
    check("w_read3", {48'h0, wd}, 64'h3C3C);
    w_dread(16'h0103, lat, wd);
    check("w_read_wrap", {48'h0, wd}, 64'h3C3C);
    w_dread(16'h0002, lat, wd);
    check("w_read2", {48'h0, wd}, 64'h0);

    // reset during WBUSY abandons the write
    l_d_writeM = 1'b1; l_d_address = 16'h0020; l_wdata = 64'h1234; l_drive = 1'b1;
    tick();
    l_d_writeM = 1'b0; l_drive = 1'b0;
    reset_n = 1'b0;
    tick();
    check("rstw_done",     {63'h0, l_d_doneM}, 64'h0);
    check("rstw_in_ready", {63'h0, l_d_input_readyM}, 64'h0);
    check("rstw_wr_addr",  {48'h0, l_d_written_address}, 64'h0);
    check("rstw_d_ready",  {63'h0, l_d_readyM}, 64'h0);
    tick();
    check("rstw_done2",    {63'h0, l_d_doneM}, 64'h0);
    reset_n = 1'b1;
    tick();
    check("rstw_in_ready_rel", {63'h0, l_d_input_readyM}, 64'h1);
    check("rstw_no_late_done", {63'h0, l_d_doneM}, 64'h0);
    l_dread(16'h0020, lat, ld);
    check("rstw_word_unchanged", ld, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The block SHALL have parameters: READ_SIZE, default 64, read-bus width in bits (16 x words per line); CACHE, default 1, 1 = line reads, 0 = single-word reads; LATENCY, default 2, cycles per access (>=1); MEM_DEPTH, default 256, words of storage (power of 2).
REQ-002 The block SHALL use clock clk and reset reset_n, where reset is synchronous and active-low.
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- i_readM  in  1  instruction read request
- i_writeM  in  1  instruction write request (ignored)
- i_address  in  16  instruction word address
- i_data  inout  READ_SIZE  instruction read data, driven only while i_readyM, else Z
- i_readyM  out  1  instruction read data valid
- i_input_readyM  out  1  constant 0 (instruction port read-only)
- d_readM  in  1  data read request
- d_writeM  in  1  data write request
- d_address  in  16  data word address
- d_data  inout  READ_SIZE  read data out / write data in (bits [15:0])
- d_readyM  out  1  data read data valid
- d_input_readyM  out  1  write can be accepted
- d_doneM  out  1  one-cycle write-complete pulse
- d_written_address  out  16  address of the completed write

Function
REQ-004 Storage SHALL be MEM_DEPTH x 16 bits, indexed by address modulo MEM_DEPTH (wrap-around).
REQ-005 Line base SHALL be address with its low log2(READ_SIZE/16) bits cleared when CACHE=1, and the exact address when CACHE=0.
REQ-006 Read data SHALL hold word base+k in bits [16k+15:16k]; words beyond MEM_DEPTH SHALL wrap.
REQ-007 Each port SHALL implement states IDLE, RBUSY, RDONE; the data port SHALL also implement WBUSY.
REQ-008 In IDLE, when readM is sampled high at a posedge, the port SHALL latch the address, load a counter with LATENCY, and enter RBUSY.
REQ-009 In RBUSY, the counter SHALL decrement each edge; at 0 the port SHALL enter RDONE, so readyM is high starting LATENCY edges after the request edge.
REQ-010 In RDONE, readyM SHALL be high and data SHALL be driven from the array contents at entry to RDONE.
REQ-011 The port SHALL remain in RDONE while readM is high and the address is unchanged.
REQ-012 From RDONE, the port SHALL return to IDLE when readM drops, or restart RBUSY when the address changes.
REQ-013 In RBUSY, a change of address or a drop of readM SHALL abort the access and restart or return to IDLE; no stale readyM SHALL appear.
REQ-014 d_input_readyM SHALL equal 1 exactly in IDLE on the data port.
REQ-015 When d_writeM and d_input_readyM are both high at a posedge, the data port SHALL latch d_address and d_data[15:0] and enter WBUSY for LATENCY cycles.
REQ-016 On WBUSY completion, the data port SHALL write the word, pulse d_doneM for exactly 1 cycle, set d_written_address to the latched address, and return to IDLE.
REQ-017 d_written_address SHALL hold its value until the next write completes.
REQ-018 Only one word SHALL be written per write, regardless of CACHE.
REQ-019 When d_readM and d_writeM are both high in IDLE, the write SHALL take priority and the read SHALL start after the write completes.
REQ-020 The data port SHALL not drive d_data while d_writeM is high.
REQ-021 The instruction and data ports SHALL operate independently.
REQ-022 A read completing in the same cycle as a write to the same word SHALL return the new value.

Reset
REQ-023 While reset_n is low at a posedge: readyM, d_doneM, d_input_readyM SHALL be 0; d_written_address SHALL be 0; both ports SHALL be IDLE; i_data and d_data SHALL be Z.
REQ-024 Reset asserted mid-access SHALL abandon that access without a write.
REQ-025 The cycle after reset releases, d_input_readyM SHALL be 1.

Configuration
REQ-026 With macro MEM_PRELOAD_EN defined, reset SHALL load the array from hex file "memory.hex" (program image, word address 0 first).
REQ-027 Without MEM_PRELOAD_EN, reset SHALL clear every word to 0000.

Verification
REQ-028 Bench SHALL cover: CACHE=1, LATENCY=2, preload words 0..3 = 1111,2222,3333,4444; i_readM at addr 0002 -> i_readyM high 2 edges later, i_data = 4444_3333_2222_1111.
REQ-029 Bench SHALL cover: d write 00A5 to addr 0010 -> d_input_readyM 0 for 2 cycles, d_doneM one-cycle pulse, d_written_address=0010; a later read of 0010 gives bits[15:0]=00A5.
REQ-030 Bench SHALL cover: read and write asserted together -> write completes first (d_doneM), then d_readyM with updated data.
REQ-031 Bench SHALL cover: address change from 0000 to 0004 during RBUSY -> no readyM for 0000, readyM after 2 further edges with line 4.
REQ-032 Bench SHALL cover: CACHE=0, READ_SIZE=16, read addr 0003 -> d_data = word 3; read of addr MEM_DEPTH+3 returns the same word.
REQ-033 Bench SHALL cover: reset asserted during WBUSY -> no d_doneM, target word unchanged, all outputs at reset values.
